// File: rtl/md_pkg.sv
// ============================================================================
// Module      : md_pkg
// Description : Shared op encodings, FSM states and constants for md_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package md_pkg;

  localparam int ITER = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

endpackage

`default_nettype wire

// File: rtl/md_sign_fix.sv
// ============================================================================
// Module      : md_sign_fix
// Description : Two's-complement sign correction of the raw unsigned result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_sign_fix #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] raw,
  input  logic              is_div,
  input  logic              q_neg,
  input  logic              r_neg,
  output logic [2*XLEN-1:0] fixed
);

  // Products negate as one 64-bit value; quotient and remainder negate independently.
  always_comb begin
    fixed = raw;
    if (is_div) begin
      fixed[2*XLEN-1:XLEN] = r_neg ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];
      fixed[XLEN-1:0]      = q_neg ? -raw[XLEN-1:0]      : raw[XLEN-1:0];
    end else if (q_neg) begin
      fixed = -raw;
    end
  end

endmodule

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
// Module      : md_unit
// Description : Iterative 34-cycle mult/multu/div/divu unit producing {hi, lo}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit
  import md_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            div_by_zero
);

  md_state_e         r_state;
  md_state_e         w_next;
  logic [4:0]        r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] w_acc_step;
  logic [2*XLEN-1:0] w_fixed;
  logic [XLEN-1:0]   r_opnd;
  logic              r_is_div;
  logic              r_q_neg;
  logic              r_r_neg;
  logic              r_dz;
  logic              r_busy;
  logic              r_done;
  logic              r_dbz;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;

  logic              w_launch;
  logic              w_is_div;
  logic              w_signed;
  logic [XLEN-1:0]   w_a_abs;
  logic [XLEN-1:0]   w_b_abs;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_diff;

  assign w_is_div = op[1];
  assign w_signed = ~op[0];
  assign w_a_abs  = (w_signed && a[XLEN-1]) ? -a : a;
  assign w_b_abs  = (w_signed && b[XLEN-1]) ? -b : b;
  assign w_launch = start && !flush && ((r_state == IDLE) || (r_state == DONE));

  // Multiply keeps the multiplier in the low half; divide keeps the dividend/quotient there.
  assign w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
  assign w_diff = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opnd};

  always_comb begin
    w_acc_step = r_acc;
    if (r_is_div) begin
      if (!w_diff[XLEN]) w_acc_step = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      else               w_acc_step = {r_acc[2*XLEN-2:0], 1'b0};
    end else begin
      if (r_acc[0]) w_acc_step = {w_sum, r_acc[XLEN-1:1]};
      else          w_acc_step = {1'b0, r_acc[2*XLEN-1:1]};
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_cnt == 5'(ITER - 1)) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
    if (flush) w_next = IDLE;
  end

  md_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .raw    (r_acc),
    .is_div (r_is_div),
    .q_neg  (r_q_neg),
    .r_neg  (r_r_neg),
    .fixed  (w_fixed)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_dz     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == RUN) || (w_next == FIX);
      r_done  <= (w_next == DONE);

      if (w_launch) begin
        r_cnt    <= '0;
        r_is_div <= w_is_div;
        r_q_neg  <= w_signed && (a[XLEN-1] ^ b[XLEN-1]);
        r_r_neg  <= w_signed && w_is_div && a[XLEN-1];
        r_dz     <= w_is_div && (b == '0);
        r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_a_abs : w_b_abs)};
        r_opnd   <= w_is_div ? w_b_abs : w_a_abs;
      end else if (r_state == RUN) begin
        r_acc <= w_acc_step;
        r_cnt <= r_cnt + 5'd1;
      end

      // Divide by zero leaves |a| in the remainder, so the sign fix restores the original a.
      if ((r_state == FIX) && !flush) begin
        r_hi  <= w_fixed[2*XLEN-1:XLEN];
        r_lo  <= r_dz ? {XLEN{1'b1}} : w_fixed[XLEN-1:0];
        r_dbz <= r_dz;
      end else if (r_state == DONE) begin
        r_dbz <= 1'b0;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// Module      : tb_md_unit
// Description : Self-checking bench for md_unit against a cycle-count model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  md_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {div_by_zero, hi, lo} from plain arithmetic.
  function automatic logic [64:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int     sx, sy;
    logic [63:0] u;
    sx = x;
    sy = y;
    case (o)
      MD_MULT: begin
        p = longint'(sx) * longint'(sy);
        return {1'b0, 64'(p)};
      end
      MD_MULTU: begin
        u = {32'd0, x} * {32'd0, y};
        return {1'b0, u};
      end
      MD_DIV: begin
        if (y == 32'd0) return {1'b1, x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {1'b0, 32'h0, 32'h80000000};
        return {1'b0, 32'(sx % sy), 32'(sx / sy)};
      end
      default: begin
        if (y == 32'd0) return {1'b1, x, 32'hFFFFFFFF};
        return {1'b0, x % y, x / y};
      end
    endcase
  endfunction

  // Cycle model: an accepted op stays busy 33 cycles, then done with the result for one cycle.
  logic        m_valid = 1'b0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [64:0] m_pend = '0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_hi = '0; m_lo = '0; m_cnt = 0;
    end else if (flush) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          {m_dz, m_hi, m_lo} = m_pend;
        end
      end else if (start) begin
        m_pend = ref_result(op, a, b);
        m_cnt  = 33;
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dz});
    end
  end

  // Launch at the next edge and wait (bounded) for done; returns at the done-cycle negedge.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    int k, nb;
    bit found;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0; nb = 0; found = 1'b0;
    while (k < 60 && !found) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) found = 1'b1;
      else if (busy === 1'b1) nb++;
    end
    chk({name, " latency"}, k, 34);
    chk({name, " busy cycles"}, nb, 33);
    chk({name, " hi"}, hi, ehi);
    chk({name, " lo"}, lo, elo);
    chk({name, " dz"}, {31'd0, div_by_zero}, {31'd0, edz});
  endtask

  initial begin
    int n_done;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset dz", {31'd0, div_by_zero}, 32'd0);

    run_op("multu max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    repeat (2) @(negedge clk);
    run_op("mult -3*7", MD_MULT, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("div -7/2 b2b", MD_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    repeat (2) @(negedge clk);
    run_op("divu 100/0", MD_DIVU, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1);
    run_op("divu 100/7", MD_DIVU, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0);
    repeat (2) @(negedge clk);
    run_op("div overflow", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op("div -100/0", MD_DIV, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1);
    run_op("div 100/-7", MD_DIV, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0);
    run_op("mult -5*-6", MD_MULT, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 1'b0);
    run_op("multu setup", MD_MULTU, 32'h80000001, 32'h00000002, 32'h00000001, 32'h00000002, 1'b0);

    // Flush mid-operation; a stray start while busy must be ignored.
    repeat (2) @(negedge clk);
    op = MD_MULTU; a = 32'd5; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_done = 0;
    for (int k = 1; k <= 45; k++) begin
      start = (k == 5);
      if (k == 5) begin op = MD_DIVU; a = 32'd77; b = 32'd9; end
      flush = (k == 10);
      @(negedge clk);
      if (k == 11) chk("flush busy", {31'd0, busy}, 32'd0);
      if (done === 1'b1) n_done++;
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    chk("flush done count", n_done, 0);
    chk("flush hi kept", hi, 32'd1);
    chk("flush lo kept", lo, 32'd2);

    // Reset mid-divide discards the operation and clears the result.
    op = MD_DIV; a = 32'hFFFFFF9C; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_done = 0;
    for (int k = 1; k <= 45; k++) begin
      rst = (k == 20);
      @(negedge clk);
      if (k == 21) begin
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
      end
      if (done === 1'b1) n_done++;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    chk("rst done count", n_done, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
